// File: rtl/yarp_alu_issue.sv
// Issue/writeback wrapper: decodes RV32I register/immediate ALU ops for an external combinational ALU.
// Latency: two registered stages (decode S1, result S2); accept at edge N gives out_valid_o after edge N+1.
// Backpressure: out_ready_i low stalls both stages; in_ready_o drops only when S1 and S2 are both full.
// Optional build macro YARP_ALU_ISSUE_PERF_EN adds retired/illegal writeback counters.
module yarp_alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic [XLEN-1:0] opr_a_o,
   output logic [XLEN-1:0] opr_b_o,
   output logic [3:0]      op_sel_o,
   input  logic [XLEN-1:0] alu_res_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [4:0]      rd_addr_o,
   output logic            rd_wr_en_o,
   output logic [XLEN-1:0] rd_data_o,
   output logic            illegal_o
`ifdef YARP_ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]     retired_cnt_o,
   output logic [31:0]     illegal_cnt_o
`endif
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SRL  = 4'd3;
   localparam logic [3:0] OP_SRA  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;

   localparam logic [6:0] OPC_REG   = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // funct3 -> ALU op; alt selects SUB/SRA where the encoding allows it
   function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
         3'b001:  f3_op = OP_SLL;
         3'b010:  f3_op = OP_SLT;
         3'b011:  f3_op = OP_SLTU;
         3'b100:  f3_op = OP_XOR;
         3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
         3'b110:  f3_op = OP_OR;
         default: f3_op = OP_AND;
      endcase
   endfunction

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_u  = {instr_i[31:12], 12'h000};

   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;
   logic [3:0]      dec_op;
   logic            dec_illegal;

   // Decode the incoming instruction into operands, op select and legality
   always_comb begin
      dec_a       = rs1_data_i;
      dec_b       = rs2_data_i;
      dec_op      = OP_ADD;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_REG: begin
            dec_op = f3_op(funct3, funct7 == F7_ALT);
            if (funct7 == F7_ALT)
               dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
            else if (funct7 != F7_ZERO)
               dec_illegal = 1'b1;
         end
         OPC_IMM: begin
            dec_b  = imm_i;
            // ADDI never becomes SUB: the alt bit only matters for shifts
            dec_op = f3_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
            if (funct3 == 3'b001)
               dec_illegal = (funct7 != F7_ZERO);
            else if (funct3 == 3'b101)
               dec_illegal = !(funct7 == F7_ZERO || funct7 == F7_ALT);
         end
         OPC_LUI: begin
            dec_a = '0;
            dec_b = imm_u;
         end
         OPC_AUIPC: begin
            dec_a = pc_i;
            dec_b = imm_u;
         end
         default: dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_a  = '0;
         dec_b  = '0;
         dec_op = OP_ADD;
      end
   end

   logic            s1_vld;
   logic [XLEN-1:0] s1_a;
   logic [XLEN-1:0] s1_b;
   logic [3:0]      s1_op;
   logic [4:0]      s1_rd;
   logic            s1_illegal;

   logic            s2_vld;
   logic [4:0]      s2_rd;
   logic            s2_wr_en;
   logic [XLEN-1:0] s2_data;
   logic            s2_illegal;

   logic s2_adv;
   logic accept;

   assign s2_adv     = s1_vld && (!s2_vld || out_ready_i);
   assign in_ready_o = !s1_vld || s2_adv;
   assign accept     = in_valid_i && in_ready_o;

   // S1: decode register; refilled on accept, emptied when it moves to S2
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_vld     <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_op      <= OP_ADD;
         s1_rd      <= '0;
         s1_illegal <= 1'b0;
      end else if (accept) begin
         s1_vld     <= 1'b1;
         s1_a       <= dec_a;
         s1_b       <= dec_b;
         s1_op      <= dec_op;
         s1_rd      <= instr_i[11:7];
         s1_illegal <= dec_illegal;
      end else if (s2_adv) begin
         s1_vld     <= 1'b0;
      end
   end

   // S2: writeback register; captures the ALU result, holds while the consumer stalls
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s2_vld     <= 1'b0;
         s2_rd      <= '0;
         s2_wr_en   <= 1'b0;
         s2_data    <= '0;
         s2_illegal <= 1'b0;
      end else if (s2_adv) begin
         s2_vld     <= 1'b1;
         s2_rd      <= s1_rd;
         s2_wr_en   <= !s1_illegal && (s1_rd != 5'd0);
         s2_data    <= s1_illegal ? '0 : alu_res_i;
         s2_illegal <= s1_illegal;
      end else if (out_ready_i) begin
         s2_vld     <= 1'b0;
      end
   end

   assign opr_a_o     = s1_a;
   assign opr_b_o     = s1_b;
   assign op_sel_o    = s1_op;
   assign out_valid_o = s2_vld;
   assign rd_addr_o   = s2_rd;
   assign rd_wr_en_o  = s2_wr_en;
   assign rd_data_o   = s2_data;
   assign illegal_o   = s2_illegal;

`ifdef YARP_ALU_ISSUE_PERF_EN
   logic [31:0] retired_cnt;
   logic [31:0] illegal_cnt;

   // Count completed writeback handshakes, split by legality; counters wrap
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         retired_cnt <= '0;
         illegal_cnt <= '0;
      end else if (s2_vld && out_ready_i) begin
         if (s2_illegal)
            illegal_cnt <= illegal_cnt + 32'd1;
         else
            retired_cnt <= retired_cnt + 32'd1;
      end
   end

   assign retired_cnt_o = retired_cnt;
   assign illegal_cnt_o = illegal_cnt;
`endif

endmodule
